sar_adc_sampler: RTL

Periodic sampling controller for the SAR ADC conversion engine. It issues start pulses at a programmable interval and captures each `eoc`/`den`/`Dout` result. Every 2^AVG_LOG2 results are averaged into one sample, which is presented to the downstream consumer through a valid/ready handshake. It sits between the ADC controller and the consumer logic, and it reports timeouts and overruns.

---
 rtl/sar_adc_sampler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sar_adc_sampler.sv
// Periodic sampling controller for the SAR ADC engine.
// Issues start pulses at a programmable interval and collects eoc/den/Dout results.
// Averages each group of 2^AVG_LOG2 results into one sample behind a valid/ready handshake.
// Sticky flags report timed-out conversions and missed ticks or dropped samples.
module sar_adc_sampler #(
  parameter int ADC_WIDTH    = 8,
  parameter int AVG_LOG2     = 2,
  parameter int PERIOD_WIDTH = 16,
  parameter int TIMEOUT      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    start,
  input  logic                    eoc,
  input  logic                    den,
  input  logic [ADC_WIDTH-1:0]    adc_dout,
  output logic                    sample_valid,
  output logic [ADC_WIDTH-1:0]    sample_data,
  input  logic                    sample_ready,
  input  logic                    err_clr,
  output logic                    timeout_err,
  output logic                    overrun_err
);

  localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
  // A zero-width count is illegal, so pass-through mode keeps one bit that never matters.
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] tick_cnt;
  logic [PERIOD_WIDTH-1:0] period_m1;
  logic [TMR_W-1:0]        timer;
  logic [ACC_W-1:0]        acc;
  logic [CNT_W-1:0]        cnt;

  logic             tick;
  logic             conv_ok;
  logic             timeout_ev;
  logic             missed_ev;
  logic             can_load;
  logic             drop_ev;
  logic [ACC_W-1:0] acc_sum;
  logic [ADC_WIDTH-1:0] avg_value;

  // A period of 0 behaves like 1: a tick in every enabled cycle.
  assign period_m1  = (period == '0) ? '0 : period - PERIOD_WIDTH'(1);
  assign tick       = en && (tick_cnt == '0);

  assign conv_ok    = (state == WAIT) && eoc && den;
  // eoc without den counts as a failed conversion, same as running out of time.
  assign timeout_ev = (state == WAIT) && !conv_ok && (eoc || (timer == TMR_W'(TIMEOUT - 1)));
  assign missed_ev  = tick && (state != IDLE);
  assign can_load   = !sample_valid || sample_ready;
  assign drop_ev    = (state == DONE) && !can_load;
  assign acc_sum    = acc + ACC_W'(adc_dout);
  assign avg_value  = ADC_WIDTH'(acc >> AVG_LOG2);

  // Tick counter: free-runs 0..period-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      tick_cnt <= '0;
    end else if (!en || (tick_cnt >= period_m1)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + PERIOD_WIDTH'(1);
    end
  end

  // Conversion FSM with registered start pulse, accumulator and output sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      start        <= 1'b0;
      timer        <= '0;
      acc          <= '0;
      cnt          <= '0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
    end else begin
      // NOTE: defaults first, case arms override; the last assignment in the block wins.
      start <= 1'b0;
      if (sample_ready) sample_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          // A disabled sampler drops any partial average once it is back at rest.
          if (!en) begin
            acc <= '0;
            cnt <= '0;
          end
          if (tick) begin
            state <= START;
            start <= 1'b1;
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + TMR_W'(1);
          if (conv_ok) begin
            acc   <= acc_sum;
            cnt   <= cnt + CNT_W'(1);
            state <= (cnt == LAST_CNT) ? DONE : IDLE;
          end else if (timeout_ev) begin
            acc   <= '0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        DONE: begin
          // A still-pending sample is kept; the new average is dropped as an overrun.
          if (can_load) begin
            sample_data  <= avg_value;
            sample_valid <= 1'b1;
          end
          acc   <= '0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new event in the same cycle beats err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (timeout_ev)   timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;

      if (missed_ev || drop_ev) overrun_err <= 1'b1;
      else if (err_clr)         overrun_err <= 1'b0;
    end
  end

endmodule
